// File: rtl/pipes.sv
// Shared pipeline types for the memory stage.
//   MemSizeType / WBType : decode control fields carried down the pipe
//   msize_t              : dbus transfer size code
//   mau_state_t          : mem_access_unit FSM states
//   STRB_*               : strobe base patterns, shifted by the byte offset
package pipes;

  typedef enum logic [2:0] {
    MSize_zero   = 3'd0,
    MSize_8bits  = 3'd1,
    MSize_16bits = 3'd2,
    MSize_32bits = 3'd3,
    MSize_64bits = 3'd4
  } MemSizeType;

  typedef enum logic [3:0] {
    WBNoHandle = 4'd0,
    WB_7       = 4'd1,
    WB_15      = 4'd2,
    WB_31      = 4'd3,
    WB_63      = 4'd4,
    WB_7_sext  = 4'd5,
    WB_15_sext = 4'd6,
    WB_31_sext = 4'd7
  } WBType;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  localparam logic [7:0] STRB_BYTE  = 8'h01;
  localparam logic [7:0] STRB_HALF  = 8'h03;
  localparam logic [7:0] STRB_WORD  = 8'h0F;
  localparam logic [7:0] STRB_DWORD = 8'hFF;

  // True for sizes that produce a real bus transfer.
  function automatic logic is_bus_size(MemSizeType s);
    logic r;
    case (s)
      MSize_8bits, MSize_16bits, MSize_32bits, MSize_64bits: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(MemSizeType s, logic [2:0] off);
    logic r;
    case (s)
      MSize_16bits: r = off[0];
      MSize_32bits: r = |off[1:0];
      MSize_64bits: r = |off;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for one dbus access.
//   offset_i    : addr[2:0] of the access
//   size_i      : access size
//   wb_type_i   : load extension kind
//   store_i     : access is a store (zeroes load result, enables strobes)
//   wdata_i     : right-aligned store data
//   rdata_raw_i : raw 64-bit read word from the bus
//   msize_o     : bus size code
//   strobe_o    : byte write enables
//   wdata_o     : store data shifted into its lanes
//   rdata_o     : aligned and extended load data
module mem_lane_align
  import pipes::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]          offset_i,
  input  MemSizeType          size_i,
  input  WBType               wb_type_i,
  input  logic                store_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_raw_i,
  output msize_t              msize_o,
  output logic [DATA_W/8-1:0] strobe_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic [5:0]        shamt;
  logic [StrbW-1:0]  strb_base;
  logic [DATA_W-1:0] raw;

  assign shamt   = {offset_i, 3'b000};
  assign wdata_o = wdata_i << shamt;
  assign raw     = rdata_raw_i >> shamt;

  always_comb begin
    msize_o   = MSIZE1;
    strb_base = '0;
    unique case (size_i)
      MSize_8bits: begin
        msize_o   = MSIZE1;
        strb_base = StrbW'(STRB_BYTE);
      end
      MSize_16bits: begin
        msize_o   = MSIZE2;
        strb_base = StrbW'(STRB_HALF);
      end
      MSize_32bits: begin
        msize_o   = MSIZE4;
        strb_base = StrbW'(STRB_WORD);
      end
      MSize_64bits: begin
        msize_o   = MSIZE8;
        strb_base = StrbW'(STRB_DWORD);
      end
      default: ;
    endcase
  end

  // A full-width access is always aligned, so the shift is a no-op there.
  assign strobe_o = store_i ? (strb_base << offset_i) : '0;

  always_comb begin
    rdata_o = raw;
    unique case (wb_type_i)
      WB_7:       rdata_o = DATA_W'(raw[7:0]);
      WB_15:      rdata_o = DATA_W'(raw[15:0]);
      WB_31:      rdata_o = DATA_W'(raw[31:0]);
      WB_7_sext:  rdata_o = {{(DATA_W-8){raw[7]}}, raw[7:0]};
      WB_15_sext: rdata_o = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      WB_31_sext: rdata_o = {{(DATA_W-32){raw[31]}}, raw[31:0]};
      default:    rdata_o = raw;
    endcase
    if (store_i) rdata_o = '0;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage dbus initiator: accepts one access descriptor, issues and holds
// the bus request until data_ok, then presents the aligned/extended result.
//   clk, reset              : clock, async active-high reset
//   in_*                    : access descriptor handshake and fields
//   out_*                   : result handshake, load data, misalign flag
//   dreq_*                  : bus request (held stable while dreq_valid)
//   dresp_*                 : bus response
module mem_access_unit
  import pipes::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic [2:0]          in_mem_size,
  input  logic [3:0]          in_wb_type,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_misalign,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data
);

  mau_state_t        state_q, state_d;
  logic              wr_q, wr_d;
  MemSizeType        size_q, size_d;
  WBType             wb_q, wb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  MemSizeType        in_size;
  logic [DATA_W-1:0] load_data;
  msize_t            msize;

  // Completion is signalled by data_ok alone; addr_ok carries no extra meaning here.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  assign in_size = MemSizeType'(in_mem_size);

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .offset_i    (addr_q[2:0]),
    .size_i      (size_q),
    .wb_type_i   (wb_q),
    .store_i     (wr_q),
    .wdata_i     (wdata_q),
    .rdata_raw_i (dresp_data),
    .msize_o     (msize),
    .strobe_o    (dreq_strobe),
    .wdata_o     (dreq_data),
    .rdata_o     (load_data)
  );

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign dreq_valid   = (state_q == REQ);
  assign dreq_addr    = addr_q;
  assign dreq_size    = msize;
  assign out_rdata    = rdata_q;
  assign out_misalign = misalign_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    size_d     = size_q;
    wb_d       = wb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Read and write both set is handled as a write.
          wr_d       = in_mem_write;
          size_d     = in_size;
          wb_d       = WBType'(in_wb_type);
          addr_d     = in_addr;
          wdata_d    = in_wdata;
          rdata_d    = '0;
          misalign_d = 1'b0;
          if (!(in_mem_read || in_mem_write) || !is_bus_size(in_size)) begin
            state_d = DONE;
          end else if (is_misaligned(in_size, in_addr[2:0])) begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dresp_data_ok) begin
          rdata_d = load_data;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      size_q     <= MSize_zero;
      wb_q       <= WBNoHandle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      wb_q       <= wb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_access_unit;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        in_mem_read, in_mem_write;
  logic [2:0]  in_mem_size;
  logic [3:0]  in_wb_type;
  logic [63:0] in_addr, in_wdata;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
  logic        out_misalign;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W (64),
    .DATA_W (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_mem_size   (in_mem_size),
    .in_wb_type    (in_wb_type),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_misalign  (out_misalign),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a descriptor for one rising edge; returns on the next falling edge.
  task automatic accept(input string tag, input logic rd, input logic wr, input MemSizeType sz,
                        input WBType wb, input logic [63:0] addr, input logic [63:0] wdata);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid     = 1'b1;
    in_mem_read  = rd;
    in_mem_write = wr;
    in_mem_size  = sz;
    in_wb_type   = wb;
    in_addr      = addr;
    in_wdata     = wdata;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Pulses data_ok (with addr_ok) for one cycle; returns in DONE.
  task automatic respond(input logic [63:0] data);
    dresp_data    = data;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
  endtask

  task automatic do_store(input string tag, input MemSizeType sz, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] exp_strb,
                          input logic [63:0] exp_data, input logic [2:0] exp_size,
                          input int wait_cyc);
    accept(tag, 1'b0, 1'b1, sz, WBNoHandle, addr, wdata);
    for (int i = 0; i <= wait_cyc; i++) begin
      chk({tag, " dreq_valid"}, 64'(dreq_valid), 64'd1);
      if (i < wait_cyc) @(negedge clk);
    end
    chk({tag, " dreq_addr"}, dreq_addr, addr);
    chk({tag, " dreq_strobe"}, 64'(dreq_strobe), 64'(exp_strb));
    chk({tag, " dreq_data"}, dreq_data, exp_data);
    chk({tag, " dreq_size"}, 64'(dreq_size), 64'(exp_size));
    respond(64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out_rdata"}, out_rdata, 64'd0);
    chk({tag, " dreq_dropped"}, 64'(dreq_valid), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input MemSizeType sz, input WBType wb,
                         input logic [63:0] addr, input logic [63:0] bus, input logic [63:0] exp);
    accept(tag, 1'b1, 1'b0, sz, wb, addr, 64'd0);
    chk({tag, " dreq_valid"}, 64'(dreq_valid), 64'd1);
    chk({tag, " dreq_strobe"}, 64'(dreq_strobe), 64'd0);
    respond(bus);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out_rdata"}, out_rdata, exp);
    chk({tag, " out_misalign"}, 64'(out_misalign), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_mem_size   = 3'd0;
    in_wb_type    = 4'd0;
    in_addr       = '0;
    in_wdata      = '0;
    out_ready     = 1'b1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_rdata", out_rdata, 64'd0);
    chk("rst out_misalign", 64'(out_misalign), 64'd0);
    chk("rst dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst dreq_addr", dreq_addr, 64'd0);
    chk("rst dreq_size", 64'(dreq_size), 64'd0);
    chk("rst dreq_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst dreq_data", dreq_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Stores: lane steering and strobes
    do_store("sb", MSize_8bits, 64'h1003, 64'hAB, 8'h08, 64'h0000_0000_AB00_0000, 3'd0, 2);
    do_store("sh", MSize_16bits, 64'h1012, 64'h1234, 8'h0C, 64'h0000_0000_1234_0000, 3'd1, 0);
    do_store("sw", MSize_32bits, 64'h1014, 64'hCAFE_BABE, 8'hF0, 64'hCAFE_BABE_0000_0000,
             3'd2, 1);

    // Loads: shift and extension
    do_load("lb", MSize_8bits, WB_7_sext, 64'h2005, 64'h0000_8000_0000_0000,
            64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", MSize_8bits, WB_7, 64'h2005, 64'h0000_8000_0000_0000, 64'h80);
    do_load("lh", MSize_16bits, WB_15_sext, 64'h2002, 64'h0000_0000_F00D_0000,
            64'hFFFF_FFFF_FFFF_F00D);
    do_load("lhu", MSize_16bits, WB_15, 64'h2002, 64'h0000_0000_F00D_0000, 64'hF00D);
    do_load("lw", MSize_32bits, WB_31_sext, 64'h2004, 64'h8765_4321_0000_0000,
            64'hFFFF_FFFF_8765_4321);
    do_load("lwu", MSize_32bits, WB_31, 64'h2004, 64'h8765_4321_0000_0000, 64'h8765_4321);

    // Misaligned word load: no request, result right after accept
    accept("lw_mis", 1'b1, 1'b0, MSize_32bits, WB_31_sext, 64'h2006, 64'd0);
    chk("lw_mis dreq_valid", 64'(dreq_valid), 64'd0);
    chk("lw_mis out_valid", 64'(out_valid), 64'd1);
    chk("lw_mis out_misalign", 64'(out_misalign), 64'd1);
    chk("lw_mis out_rdata", out_rdata, 64'd0);
    @(negedge clk);

    // ld with data_ok held off 5 cycles and out_ready held off 3 cycles
    out_ready = 1'b0;
    accept("ld", 1'b1, 1'b0, MSize_64bits, WB_63, 64'h3000, 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ld dreq_valid", 64'(dreq_valid), 64'd1);
      chk("ld dreq_addr", dreq_addr, 64'h3000);
      chk("ld dreq_size", 64'(dreq_size), 64'd3);
      chk("ld dreq_strobe", 64'(dreq_strobe), 64'd0);
      chk("ld in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    respond(64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      chk("ld out_valid", 64'(out_valid), 64'd1);
      chk("ld out_rdata", out_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("ld in_ready", 64'(in_ready), 64'd0);
      chk("ld dreq_off", 64'(dreq_valid), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("ld release out_valid", 64'(out_valid), 64'd0);

    // Non-memory op; stray data_ok in IDLE/DONE must be ignored
    dresp_data_ok = 1'b1;
    accept("nop", 1'b0, 1'b0, MSize_64bits, WB_63, 64'h5000, 64'h1234);
    chk("nop dreq_valid", 64'(dreq_valid), 64'd0);
    chk("nop out_valid", 64'(out_valid), 64'd1);
    chk("nop out_rdata", out_rdata, 64'd0);
    chk("nop out_misalign", 64'(out_misalign), 64'd0);
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("nop idle", 64'(in_ready), 64'd1);

    // Reset mid-REQ, then a late data_ok
    accept("rst_req", 1'b1, 1'b0, MSize_64bits, WB_63, 64'h4000, 64'd0);
    chk("rst_req dreq_valid", 64'(dreq_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_req async dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_req async in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    dresp_data = 64'h1111_2222_3333_4444;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("rst_req late out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("rst_req out_valid", 64'(out_valid), 64'd0);
    chk("rst_req in_ready", 64'(in_ready), 64'd1);
    chk("rst_req out_rdata", out_rdata, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
